wb_arbiter: RTL and testbench

- Writeback stage that sits directly upstream of the register file and drives its single write port (w_en, w_idx, w_data).
- Merges two result sources into that port:
  - single-cycle ALU results;
  - variable-latency load responses from data memory, which are buffered, byte/half-extracted and sign/zero-extended here.
- Keeps a pending-load scoreboard that decode reads to stall on load-use hazards.

---
 rtl/wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with buffered, formatted
// load responses into the register-file write port, and tracks pending loads
// for decode's load-use hazard check.
module wb_arbiter #(
  parameter int LD_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [2:0]  mem_funct3,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] pending,
  output logic        w_en,
  output logic [4:0]  w_idx,
  output logic [31:0] w_data
);

  localparam int AW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  // Load response storage; payload needs no reset because count gates its use
  logic [4:0]  fifo_rd     [LD_DEPTH];
  logic [2:0]  fifo_funct3 [LD_DEPTH];
  logic [1:0]  fifo_lo     [LD_DEPTH];
  logic [31:0] fifo_data   [LD_DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] starve_cnt;

  logic        empty;
  logic        push;
  logic        pop;
  logic        force_head;
  logic        alu_win;
  logic [4:0]  head_rd;
  logic [2:0]  head_funct3;
  logic [1:0]  head_lo;
  logic [31:0] head_data;
  logic [7:0]  head_byte;
  logic [15:0] head_half;
  logic [31:0] head_fmt;
  logic        win_valid;
  logic [4:0]  win_rd;
  logic [31:0] win_data;
  logic [31:0] pending_next;

  assign empty       = (count == '0);
  assign mem_ready   = (count < (AW + 1)'(LD_DEPTH));
  assign push        = mem_valid && mem_ready;
  assign force_head  = !empty && (starve_cnt == CW'(STARVE_MAX));
  assign alu_win     = alu_valid && !force_head;
  assign pop         = !alu_win && !empty;
  assign alu_stall   = alu_valid && force_head;

  assign head_rd     = fifo_rd[rd_ptr];
  assign head_funct3 = fifo_funct3[rd_ptr];
  assign head_lo     = fifo_lo[rd_ptr];
  assign head_data   = fifo_data[rd_ptr];

  // Extract and sign/zero-extend the addressed byte or half of the head word
  always_comb begin
    head_byte = 8'(head_data >> {head_lo, 3'b000});
    head_half = head_lo[1] ? head_data[31:16] : head_data[15:0];
    head_fmt  = head_data;
    case (head_funct3)
      3'b000:  head_fmt = {{24{head_byte[7]}}, head_byte};
      3'b100:  head_fmt = {24'd0, head_byte};
      3'b001:  head_fmt = {{16{head_half[15]}}, head_half};
      3'b101:  head_fmt = {16'd0, head_half};
      default: head_fmt = head_data;
    endcase
  end

  // Select this cycle's winner and the scoreboard update (set beats clear)
  always_comb begin
    win_valid    = 1'b0;
    win_rd       = 5'd0;
    win_data     = 32'd0;
    pending_next = pending;
    if (alu_win) begin
      win_valid = 1'b1;
      win_rd    = alu_rd;
      win_data  = alu_data;
    end else if (pop) begin
      win_valid = 1'b1;
      win_rd    = head_rd;
      win_data  = head_fmt;
    end
    if (pop && head_rd != 5'd0) begin
      pending_next[head_rd] = 1'b0;
    end
    if (issue_valid && issue_rd != 5'd0) begin
      pending_next[issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // Capture an accepted load beat into the tail slot
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]     <= mem_rd;
      fifo_funct3[wr_ptr] <= mem_funct3;
      fifo_lo[wr_ptr]     <= mem_addr_lo;
      fifo_data[wr_ptr]   <= mem_data;
    end
  end

  // FIFO pointers, occupancy and the starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW + 1)'(1);
      end
      if (pop) begin
        starve_cnt <= '0;
      end else if (!empty && alu_win) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

  // Register the winner into the write port; x0 results are dropped silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en    <= 1'b0;
      w_idx   <= 5'd0;
      w_data  <= 32'd0;
      pending <= 32'd0;
    end else begin
      pending <= pending_next;
      w_en    <= win_valid && (win_rd != 5'd0);
      if (win_valid && win_rd != 5'd0) begin
        w_idx  <= win_rd;
        w_data <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: load-format vector table plus
// hand-written starvation, full-FIFO, scoreboard and async-reset sequences.
// Expected register-file writes are queued as stimulus is driven and matched
// in order whenever the DUT asserts w_en.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] pending;
  logic        w_en;
  logic [4:0]  w_idx;
  logic [31:0] w_data;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [1:0]  lo;
    logic [31:0] data;
    logic [31:0] expected;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_exp;
  vec_t vecs[12];
  int   tests_run;
  int   tests_failed;

  wb_arbiter #(.LD_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .pending(pending),
    .w_en(w_en), .w_idx(w_idx), .w_data(w_data)
  );

  // 10-unit clock, posedges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running, required finish");
    $fatal(1, "[TB] timeout");
  end

  // Match every observed register-file write against the expectation queue
  always @(negedge clk) begin
    if (rst_n && w_en) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_write: got idx=%0d data=%h, required no write", w_idx, w_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (w_idx !== mon_exp.idx || w_data !== mon_exp.data) begin
          tests_failed++;
          $display("[TB] FAIL write_order: got idx=%0d data=%h, required idx=%0d data=%h",
                   w_idx, w_data, mon_exp.idx, mon_exp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  task automatic expectWrite(input logic [4:0] idx, input logic [31:0] data);
    exp_q.push_back({idx, data});
  endtask

  // Push one load beat with the ALU idle, then let it drain
  task automatic applyStimulus(input vec_t v);
    mem_valid   = 1'b1;
    mem_rd      = v.rd;
    mem_funct3  = v.funct3;
    mem_addr_lo = v.lo;
    mem_data    = v.data;
    #1;
    checkOutput("ready_when_empty", {31'd0, mem_ready}, 32'd1);
    if (v.rd != 5'd0) expectWrite(v.rd, v.expected);
    tick();
    mem_valid = 1'b0;
    checkOutput("no_bypass", {31'd0, w_en}, 32'd0);
    tick();
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    alu_valid    = 1'b0;
    alu_rd       = 5'd0;
    alu_data     = 32'd0;
    mem_valid    = 1'b0;
    mem_rd       = 5'd0;
    mem_funct3   = 3'd0;
    mem_addr_lo  = 2'd0;
    mem_data     = 32'd0;
    issue_valid  = 1'b0;
    issue_rd     = 5'd0;

    vecs[0]  = '{5'd7, 3'b000, 2'd3, 32'h80FF1234, 32'hFFFFFF80};
    vecs[1]  = '{5'd7, 3'b100, 2'd3, 32'h80FF1234, 32'h00000080};
    vecs[2]  = '{5'd7, 3'b001, 2'd2, 32'h80FF1234, 32'hFFFF80FF};
    vecs[3]  = '{5'd7, 3'b101, 2'd1, 32'h80FF1234, 32'h00001234};
    vecs[4]  = '{5'd8, 3'b010, 2'd0, 32'h80FF1234, 32'h80FF1234};
    vecs[5]  = '{5'd8, 3'b000, 2'd1, 32'h80FF1234, 32'h00000012};
    vecs[6]  = '{5'd8, 3'b100, 2'd2, 32'h80FF1234, 32'h000000FF};
    vecs[7]  = '{5'd8, 3'b001, 2'd1, 32'h80FF1234, 32'h00001234};
    vecs[8]  = '{5'd8, 3'b011, 2'd3, 32'h80FF1234, 32'h80FF1234};
    vecs[9]  = '{5'd8, 3'b101, 2'd3, 32'h80FF1234, 32'h000080FF};
    vecs[10] = '{5'd8, 3'b000, 2'd0, 32'h80FF1234, 32'h00000034};
    vecs[11] = '{5'd0, 3'b010, 2'd0, 32'hCAFEF00D, 32'h00000000};

    // Reset state
    #12;
    checkOutput("rst_w_en", {31'd0, w_en}, 32'd0);
    checkOutput("rst_w_idx", {27'd0, w_idx}, 32'd0);
    checkOutput("rst_w_data", w_data, 32'd0);
    checkOutput("rst_pending", pending, 32'd0);
    checkOutput("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // ALU only
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    #1;
    checkOutput("alu_stall_idle", {31'd0, alu_stall}, 32'd0);
    expectWrite(5'd5, 32'hDEADBEEF);
    tick();
    alu_valid = 1'b0;
    tick();
    tick();

    // Load formatting table
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
    end

    // Starvation: load queued behind continuous ALU traffic
    alu_valid   = 1'b1;
    alu_rd      = 5'd3;
    alu_data    = 32'h100;
    mem_valid   = 1'b1;
    mem_rd      = 5'd7;
    mem_funct3  = 3'b010;
    mem_addr_lo = 2'd0;
    mem_data    = 32'h11111111;
    #1;
    checkOutput("starve_stall_0", {31'd0, alu_stall}, 32'd0);
    expectWrite(5'd3, 32'h100);
    tick();
    mem_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      alu_data = 32'h100 + 32'(k);
      #1;
      checkOutput("starve_alu_wins", {31'd0, alu_stall}, 32'd0);
      expectWrite(5'd3, 32'h100 + 32'(k));
      tick();
    end
    alu_data = 32'h105;
    #1;
    checkOutput("starve_forced", {31'd0, alu_stall}, 32'd1);
    expectWrite(5'd7, 32'h11111111);
    tick();
    checkOutput("starve_released", {31'd0, alu_stall}, 32'd0);
    expectWrite(5'd3, 32'h105);
    tick();
    alu_valid = 1'b0;
    tick();
    tick();

    // FIFO full during continuous ALU traffic
    alu_valid   = 1'b1;
    alu_rd      = 5'd4;
    mem_funct3  = 3'b010;
    mem_addr_lo = 2'd0;
    for (int k = 0; k < 5; k++) begin
      alu_data  = 32'h200 + 32'(k);
      mem_valid = 1'b1;
      mem_rd    = 5'd10 + 5'(k < 2 ? k : 2);
      mem_data  = (k == 0) ? 32'hAAAA0000 : (k == 1) ? 32'hBBBB0000 : 32'hCCCC0000;
      #1;
      checkOutput("full_ready", {31'd0, mem_ready}, (k < 2) ? 32'd1 : 32'd0);
      expectWrite(5'd4, 32'h200 + 32'(k));
      tick();
    end
    alu_data = 32'h205;
    #1;
    checkOutput("full_forced", {31'd0, alu_stall}, 32'd1);
    checkOutput("full_still_blocked", {31'd0, mem_ready}, 32'd0);
    expectWrite(5'd10, 32'hAAAA0000);
    tick();
    checkOutput("full_ready_after_pop", {31'd0, mem_ready}, 32'd1);
    expectWrite(5'd4, 32'h205);
    expectWrite(5'd11, 32'hBBBB0000);
    expectWrite(5'd12, 32'hCCCC0000);
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    tick();
    tick();
    tick();

    // Scoreboard
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    issue_valid = 1'b0;
    checkOutput("sb_set", pending, 32'h00000200);
    mem_valid  = 1'b1;
    mem_rd     = 5'd9;
    mem_data   = 32'h00009999;
    expectWrite(5'd9, 32'h00009999);
    tick();
    mem_valid   = 1'b0;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    issue_valid = 1'b0;
    checkOutput("sb_set_wins", pending, 32'h00000200);
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    tick();
    issue_valid = 1'b0;
    checkOutput("sb_issue_x0", pending, 32'h00000200);
    alu_valid = 1'b1;
    alu_rd    = 5'd9;
    alu_data  = 32'h5;
    expectWrite(5'd9, 32'h5);
    tick();
    alu_valid = 1'b0;
    checkOutput("sb_alu_no_clear", pending, 32'h00000200);
    mem_valid = 1'b1;
    mem_data  = 32'h6;
    expectWrite(5'd9, 32'h6);
    tick();
    mem_valid = 1'b0;
    tick();
    checkOutput("sb_load_clear", pending, 32'h00000000);
    tick();

    // Reset mid-operation with two queued loads and pending x7, x9
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_rd      = 5'd2;
    alu_data    = 32'h300;
    mem_valid   = 1'b1;
    mem_rd      = 5'd7;
    mem_data    = 32'h77;
    expectWrite(5'd2, 32'h300);
    tick();
    alu_data = 32'h301;
    mem_rd   = 5'd9;
    mem_data = 32'h99;
    expectWrite(5'd2, 32'h301);
    tick();
    mem_valid = 1'b0;
    alu_data  = 32'h302;
    expectWrite(5'd2, 32'h302);
    tick();
    checkOutput("pre_rst_pending", pending, 32'h00000280);
    checkOutput("pre_rst_full", {31'd0, mem_ready}, 32'd0);
    #1;
    rst_n     = 1'b0;
    alu_valid = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("async_rst_w_en", {31'd0, w_en}, 32'd0);
    checkOutput("async_rst_pending", pending, 32'd0);
    checkOutput("async_rst_ready", {31'd0, mem_ready}, 32'd1);
    checkOutput("async_rst_w_data", w_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("post_rst_no_write", {31'd0, w_en}, 32'd0);
    end
    checkOutput("post_rst_pending", pending, 32'd0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
